// File: rtl/mux_arb_nway.sv
// N-channel valid/ready arbiter (fixed priority or round-robin) feeding a one-entry output register.
// Latency 1 cycle; while the held word is stalled (Out_Valid && !Out_Ready) In_Ready is all 0 and the output holds.
module mux_arb_nway #(
    parameter int WIDTH = 8,
    parameter int NCH   = 3,
    parameter int RR    = 0,
    parameter int SW    = $clog2(NCH)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NCH*WIDTH-1:0] In_Data,
    input  logic [NCH-1:0]       In_Valid,
    output logic [NCH-1:0]       In_Ready,
    output logic [WIDTH-1:0]     Out_Data,
    output logic [SW-1:0]        Out_Src,
    output logic                 Out_Valid,
    input  logic                 Out_Ready
);

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_dat_q, out_dat_d;
    logic [SW-1:0]    out_src_q, out_src_d;
    logic [SW-1:0]    last_q, last_d;

    logic             load_en;
    logic             win_vld;
    logic             found;
    int               scan_idx;
    logic [SW-1:0]    win_idx;
    logic [WIDTH-1:0] win_dat;

    assign load_en = !out_vld_q || Out_Ready;

    // Round-robin scans Last+1, Last+2, ... wrapping at NCH, which need not be a power of two.
    always_comb begin
        win_vld  = |In_Valid;
        win_idx  = '0;
        found    = 1'b0;
        scan_idx = 0;
        if (RR != 0) begin
            for (int k = 1; k <= NCH; k++) begin
                scan_idx = int'(last_q) + k;
                if (scan_idx >= NCH) begin
                    scan_idx = scan_idx - NCH;
                end
                if (!found && In_Valid[scan_idx]) begin
                    found   = 1'b1;
                    win_idx = SW'(scan_idx);
                end
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (In_Valid[i]) begin
                    win_idx = SW'(i);
                end
            end
        end
    end

    always_comb begin
        win_dat = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win_idx == SW'(i)) begin
                win_dat = In_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        In_Ready = '0;
        for (int i = 0; i < NCH; i++) begin
            In_Ready[i] = load_en && !Reset && win_vld && (win_idx == SW'(i));
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_src_d = out_src_q;
        last_d    = last_q;
        if (load_en) begin
            out_vld_d = win_vld;
            if (win_vld) begin
                out_dat_d = win_dat;
                out_src_d = win_idx;
                if (RR != 0) begin
                    last_d = win_idx;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_src_q <= '0;
            last_q    <= SW'(NCH - 1);
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_src_q <= out_src_d;
            last_q    <= last_d;
        end
    end

    assign Out_Valid = out_vld_q;
    assign Out_Data  = out_dat_q;
    assign Out_Src   = out_src_q;

endmodule

// File: tb/tb_mux_arb_nway.sv
// Directed bench for mux_arb_nway: three instances (3ch fixed, 3ch round-robin, 5ch/16b round-robin)
// checked against a scoreboard of expected words pushed at each predicted grant.
module tb_mux_arb_nway;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [23:0] a_data;
    logic [2:0]  a_vld, a_rdy;
    logic [7:0]  a_odat;
    logic [1:0]  a_osrc;
    logic        a_ovld, a_ordy;

    logic [23:0] b_data;
    logic [2:0]  b_vld, b_rdy;
    logic [7:0]  b_odat;
    logic [1:0]  b_osrc;
    logic        b_ovld, b_ordy;

    logic [79:0] c_data;
    logic [4:0]  c_vld, c_rdy;
    logic [15:0] c_odat;
    logic [2:0]  c_osrc;
    logic        c_ovld, c_ordy;

    mux_arb_nway #(.WIDTH(8), .NCH(3), .RR(0)) u_fp (
        .Clk(clk), .Reset(rst), .In_Data(a_data), .In_Valid(a_vld), .In_Ready(a_rdy),
        .Out_Data(a_odat), .Out_Src(a_osrc), .Out_Valid(a_ovld), .Out_Ready(a_ordy)
    );

    mux_arb_nway #(.WIDTH(8), .NCH(3), .RR(1)) u_rr (
        .Clk(clk), .Reset(rst), .In_Data(b_data), .In_Valid(b_vld), .In_Ready(b_rdy),
        .Out_Data(b_odat), .Out_Src(b_osrc), .Out_Valid(b_ovld), .Out_Ready(b_ordy)
    );

    mux_arb_nway #(.WIDTH(16), .NCH(5), .RR(1)) u_rr5 (
        .Clk(clk), .Reset(rst), .In_Data(c_data), .In_Valid(c_vld), .In_Ready(c_rdy),
        .Out_Data(c_odat), .Out_Src(c_osrc), .Out_Valid(c_ovld), .Out_Ready(c_ordy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] dat [3][5];

    typedef struct {
        int          d;
        logic [2:0]  src;
        logic [15:0] data;
    } exp_t;
    exp_t sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [4:0] vld, input logic ordy);
        case (d)
            0: begin
                a_vld  = vld[2:0];
                a_ordy = ordy;
                for (int i = 0; i < 3; i++) a_data[i*8 +: 8] = dat[0][i][7:0];
            end
            1: begin
                b_vld  = vld[2:0];
                b_ordy = ordy;
                for (int i = 0; i < 3; i++) b_data[i*8 +: 8] = dat[1][i][7:0];
            end
            default: begin
                c_vld  = vld;
                c_ordy = ordy;
                for (int i = 0; i < 5; i++) c_data[i*16 +: 16] = dat[2][i];
            end
        endcase
    endtask

    task automatic sample(input int d, output logic [4:0] rdy, output logic ovld,
                          output logic [2:0] osrc, output logic [15:0] odat);
        case (d)
            0: begin
                rdy = {2'b00, a_rdy}; ovld = a_ovld; osrc = {1'b0, a_osrc}; odat = {8'h00, a_odat};
            end
            1: begin
                rdy = {2'b00, b_rdy}; ovld = b_ovld; osrc = {1'b0, b_osrc}; odat = {8'h00, b_odat};
            end
            default: begin
                rdy = c_rdy; ovld = c_ovld; osrc = c_osrc; odat = c_odat;
            end
        endcase
    endtask

    task automatic chk_out(input int d, input logic exp_vld, input logic [2:0] exp_src,
                           input logic [15:0] exp_dat, input string tag);
        logic [4:0]  rdy;
        logic        ovld;
        logic [2:0]  osrc;
        logic [15:0] odat;
        sample(d, rdy, ovld, osrc, odat);
        chk({tag, " out_valid"}, 32'(ovld), 32'(exp_vld));
        if (exp_vld) begin
            chk({tag, " out_src"}, 32'(osrc), 32'(exp_src));
            chk({tag, " out_data"}, 32'(odat), 32'(exp_dat));
        end
    endtask

    // Drive one cycle, check the combinational grant, then check the word the edge captured.
    task automatic step(input int d, input logic [4:0] vld, input logic ordy,
                        input logic [4:0] exp_rdy, input string tag);
        logic [4:0]  rdy;
        logic        ovld;
        logic [2:0]  osrc;
        logic [15:0] odat;
        exp_t        e;
        bit          pushed;
        pushed = 1'b0;
        e.d    = d;
        e.src  = '0;
        e.data = '0;
        drive(d, vld, ordy);
        #1;
        sample(d, rdy, ovld, osrc, odat);
        chk({tag, " in_ready"}, 32'(rdy), 32'(exp_rdy));
        for (int i = 0; i < 5; i++) begin
            if (exp_rdy[i]) begin
                e.src  = 3'(i);
                e.data = dat[d][i];
                pushed = 1'b1;
            end
        end
        if (pushed) sb.push_back(e);
        @(posedge clk);
        #1;
        sample(d, rdy, ovld, osrc, odat);
        if (pushed) begin
            e = sb.pop_front();
            chk({tag, " out_valid"}, 32'(ovld), 32'd1);
            chk({tag, " out_src"}, 32'(osrc), 32'(e.src));
            chk({tag, " out_data"}, 32'(odat), 32'(e.data));
        end
    endtask

    initial begin
        logic [4:0]  rdy;
        logic        ovld;
        logic [2:0]  osrc;
        logic [15:0] odat;

        dat[0][0] = 16'h11; dat[0][1] = 16'h22; dat[0][2] = 16'h33;
        dat[1][0] = 16'h11; dat[1][1] = 16'h22; dat[1][2] = 16'h33;
        for (int i = 0; i < 5; i++) dat[2][i] = 16'hC000 + 16'(i * 16'h0111);
        for (int i = 3; i < 5; i++) begin
            dat[0][i] = '0;
            dat[1][i] = '0;
        end

        // Reset with every channel requesting: no grants may appear.
        rst = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 5'b11111, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int d = 0; d < 3; d++) begin
                sample(d, rdy, ovld, osrc, odat);
                chk($sformatf("reset%0d dut%0d in_ready", c, d), 32'(rdy), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            drive(d, 5'b00000, 1'b1);
            sample(d, rdy, ovld, osrc, odat);
            chk($sformatf("post_reset dut%0d out_valid", d), 32'(ovld), 32'd0);
            chk($sformatf("post_reset dut%0d out_data", d), 32'(odat), 32'd0);
            chk($sformatf("post_reset dut%0d out_src", d), 32'(osrc), 32'd0);
        end

        // Fixed priority: highest valid index wins.
        step(0, 5'b00011, 1'b1, 5'b00010, "fp_011");
        step(0, 5'b00111, 1'b1, 5'b00100, "fp_111");
        step(0, 5'b00001, 1'b1, 5'b00001, "fp_001");
        step(0, 5'b00000, 1'b1, 5'b00000, "fp_idle");
        chk_out(0, 1'b0, 3'd0, 16'h0, "fp_drain");

        // Round-robin: first scan after reset starts at channel 0.
        step(1, 5'b00111, 1'b1, 5'b00001, "rr_all0");
        step(1, 5'b00111, 1'b1, 5'b00010, "rr_all1");
        step(1, 5'b00111, 1'b1, 5'b00100, "rr_all2");
        step(1, 5'b00111, 1'b1, 5'b00001, "rr_all3");
        step(1, 5'b00111, 1'b1, 5'b00010, "rr_all4");
        step(1, 5'b00111, 1'b1, 5'b00100, "rr_all5");
        step(1, 5'b00111, 1'b1, 5'b00001, "rr_pre0");
        step(1, 5'b00111, 1'b1, 5'b00010, "rr_pre1");
        step(1, 5'b00110, 1'b1, 5'b00100, "rr_12_a");
        step(1, 5'b00110, 1'b1, 5'b00010, "rr_12_b");

        // Backpressure: held word stays put and nothing is accepted.
        dat[1][0] = 16'hA5;
        step(1, 5'b00001, 1'b1, 5'b00001, "bp_load");
        for (int c = 0; c < 4; c++) begin
            step(1, 5'b00010, 1'b0, 5'b00000, $sformatf("bp_stall%0d", c));
            chk_out(1, 1'b1, 3'd0, 16'hA5, $sformatf("bp_hold%0d", c));
        end
        step(1, 5'b00010, 1'b1, 5'b00010, "bp_release");
        step(1, 5'b00000, 1'b1, 5'b00000, "bp_idle");
        chk_out(1, 1'b0, 3'd0, 16'h0, "bp_drain");

        // Non-power-of-two wrap: park the pointer on 3, then ch4/ch0 must alternate.
        step(2, 5'b01000, 1'b1, 5'b01000, "w5_ch3");
        step(2, 5'b10001, 1'b1, 5'b10000, "w5_a4");
        step(2, 5'b10001, 1'b1, 5'b00001, "w5_a0");
        step(2, 5'b10001, 1'b1, 5'b10000, "w5_b4");
        step(2, 5'b10001, 1'b1, 5'b00001, "w5_b0");
        step(2, 5'b00000, 1'b1, 5'b00000, "w5_idle");

        // Reset while stalled: word discarded, round-robin restarts at channel 0.
        dat[1][0] = 16'h5A;
        step(1, 5'b00001, 1'b1, 5'b00001, "mr_load");
        step(1, 5'b00000, 1'b0, 5'b00000, "mr_stall");
        chk_out(1, 1'b1, 3'd0, 16'h5A, "mr_hold");
        rst = 1'b1;
        drive(1, 5'b00111, 1'b0);
        #1;
        sample(1, rdy, ovld, osrc, odat);
        chk("mr_reset in_ready", 32'(rdy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_out(1, 1'b0, 3'd0, 16'h0, "mr_after");
        step(1, 5'b00111, 1'b1, 5'b00001, "mr_restart");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arb_nway.md
# mux_arb_nway

Parametrised N-channel, W-bit registered selector that grows the three-input priority mux into a sequential arbiter. Each input channel carries a valid/ready handshake. One winner per cycle is chosen by fixed priority or round-robin and captured into a one-entry output register with its own valid/ready handshake. The block sits between multiple data producers, such as heap or memory read ports, and a single consumer that may stall.

## Interface
Parameters:
- WIDTH, 8, data width of every channel and of the output.
- NCH, 3, number of input channels; legal range 2..16; not required to be a power of two.
- RR, 0, arbitration mode:
  - 0: fixed priority, highest index wins.
  - 1: round-robin.
- SW, $clog2(NCH), width of the source index (derived; not to be overridden).

Ports:
- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- In_Data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- In_Valid  input  NCH  per-channel request.
- In_Ready  output  NCH  per-channel grant/accept; combinational; at most one bit high.
- Out_Data  output  WIDTH  registered selected word.
- Out_Src  output  SW  registered index of the channel that supplied Out_Data.
- Out_Valid  output  1  Out_Data/Out_Src hold a word.
- Out_Ready  input  1  consumer accepts the word this cycle.

## Operation
- Load enable: LE = !Out_Valid || Out_Ready.
- Winner selection (combinational, from In_Valid and mode state):
  - RR=0: the highest-index i with In_Valid[i]=1.
  - RR=1: the first i with In_Valid[i]=1, scanning Last+1, Last+2, … modulo NCH. Last is the registered index of the previous grant.
- In_Ready[w] = LE && Reset==0 && In_Valid[w] for the winner w. All other bits are 0. When no channel is valid, In_Ready is all 0.
- A transfer on channel i occurs when In_Valid[i] && In_Ready[i] on a rising edge.
- On a clock edge with LE=1 and a winner w:
  - Out_Data <= In_Data[w].
  - Out_Src <= w.
  - Out_Valid <= 1.
  - Last <= w (RR=1 only).
- On a clock edge with LE=1 and no valid channel: Out_Valid <= 0. Out_Data and Out_Src hold their values and are don't-care to the consumer.
- On a clock edge with LE=0 (stalled): all registers hold and In_Ready is all 0.
- Last changes only on a grant. Wrap: from Last=NCH-1 the scan starts at 0.
- Two states are implied by Out_Valid:
  - EMPTY (Out_Valid=0): always loads.
  - FULL (Out_Valid=1): loads only when Out_Ready=1, passing the word through on the same edge.
- Out_Ready while Out_Valid=0 is ignored.
- Data is not modified. No width conversion or arithmetic.

## Timing
- Reset values:
  - Out_Valid=0.
  - Out_Data=0.
  - Out_Src=0.
  - Last=NCH-1, so the first RR scan starts at channel 0.
  - In_Ready is all 0 during any cycle with Reset=1.
- Latency: 1 cycle from an input transfer to Out_Valid=1 with that word.
- Throughput: 1 word per cycle while Out_Ready is held high.
- Stall: while Out_Valid=1 and Out_Ready=0:
  - Out_Data, Out_Src and Out_Valid are stable.
  - No input is accepted.
- Simultaneous consume and load (FULL with Out_Ready=1 and a winner present): the old word leaves and the new word is captured on the same edge. Out_Valid stays 1.
- Reset mid-operation: a held output word is discarded, the RR pointer returns to NCH-1, and no input transfer occurs in the reset cycle.
- A producer must hold In_Valid and In_Data until its In_Ready is seen high. The arbiter may grant other channels in the meantime.

## Test plan
- Reset: assert Reset for 2 cycles with all In_Valid=1. Require In_Ready=0 throughout; after release, Out_Valid=0, Out_Data=0, Out_Src=0.
- Fixed priority (NCH=3, RR=0, Out_Ready=1): In_Valid=3'b011 with data 0x11/0x22 on channels 0/1. Require a grant to ch1 and, next cycle, Out_Data=0x22, Out_Src=1. Then In_Valid=3'b111 with ch2=0x33: require Out_Data=0x33, Out_Src=2.
- Round-robin (NCH=3, RR=1, Out_Ready=1): all In_Valid=1 for 6 cycles. Require the grant sequence 0,1,2,0,1,2. Then only ch1 and ch2 valid after a ch1 grant: require ch2 next, then ch1.
- Backpressure: load 0xA5 from ch0, then hold Out_Ready=0 for 4 cycles with ch1 valid. Require Out_Data=0xA5, Out_Valid=1 and In_Ready=0 for all 4 cycles. Release Out_Ready: 0xA5 is consumed and ch1's word is captured on the same edge.
- Non-power-of-two wrap (NCH=5, WIDTH=16, RR=1): only ch4 and ch0 valid. Require alternating grants 4,0,4,0 with Out_Src matching and no idle cycles.
- Reset mid-stall: Out_Valid=1 holding 0x5A with Out_Ready=0; pulse Reset for 1 cycle. Require Out_Valid=0 next cycle and the RR scan restarting at ch0.
